// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-shot access sequencer in front of the data memory.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority to port 0 (default build: round-robin).
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [DM_ADDRESS-1:0] req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  input  logic [2:0]            req0_funct3,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [DM_ADDRESS-1:0] req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  input  logic [2:0]            req1_funct3,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_W-1:0]     rsp0_rdata,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_W-1:0]     rsp1_rdata,
  output logic                  rsp1_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [DM_ADDRESS-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]     cmd_wdata_q, cmd_wdata_d;
  logic [2:0]            cmd_funct3_q, cmd_funct3_d;
  logic                  cmd_id_q, cmd_id_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic                  last_grant_q, last_grant_d;
`endif

  logic                  grant0, grant1, accept, misaligned;
  logic                  sel_write;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [2:0]            sel_funct3;

  // Grants are only offered in IDLE; on a tie the port that did not win last time goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !reset) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      grant0 = req0_valid;
`else
      grant0 = req0_valid && (!req1_valid || last_grant_q);
`endif
      grant1 = req1_valid && !grant0;
    end
  end

  assign accept     = grant0 | grant1;
  assign sel_write  = grant1 ? req1_write  : req0_write;
  assign sel_addr   = grant1 ? req1_addr   : req0_addr;
  assign sel_wdata  = grant1 ? req1_wdata  : req0_wdata;
  assign sel_funct3 = grant1 ? req1_funct3 : req0_funct3;

  // Unknown size codes are checked as words.
  always_comb begin
    case (sel_funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001:         misaligned = sel_addr[0];
      default:        misaligned = (sel_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_funct3_d = cmd_funct3_q;
    cmd_id_d     = cmd_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_write_d  = sel_write;
          cmd_addr_d   = sel_addr;
          cmd_wdata_d  = sel_wdata;
          cmd_funct3_d = sel_funct3;
          cmd_id_d     = grant1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_grant_d = grant1;
`endif
          rsp_data_d   = '0;
          rsp_err_d    = misaligned;
          state_d      = misaligned ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d = cmd_write_q ? '0 : rd;
        state_d    = RESP;
      end
      RESP: begin
        if (cmd_id_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_funct3_q <= '0;
      cmd_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_funct3_q <= cmd_funct3_d;
      cmd_id_q     <= cmd_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Memory-side outputs are forced to zero outside the single ISSUE cycle.
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign MemRead    = (state_q == ISSUE) && !cmd_write_q;
  assign MemWrite   = (state_q == ISSUE) && cmd_write_q;
  assign a          = (state_q == ISSUE) ? cmd_addr_q   : '0;
  assign wd         = (state_q == ISSUE) ? cmd_wdata_q  : '0;
  assign Funct3     = (state_q == ISSUE) ? cmd_funct3_q : '0;
  assign rsp0_valid = (state_q == RESP) && !cmd_id_q;
  assign rsp1_valid = (state_q == RESP) && cmd_id_q;
  assign rsp0_rdata = rsp0_valid ? rsp_data_q : '0;
  assign rsp1_rdata = rsp1_valid ? rsp_data_q : '0;
  assign rsp0_err   = rsp0_valid && rsp_err_q;
  assign rsp1_err   = rsp1_valid && rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [8:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        rsp_rdy    [2];
  wire  [1:0]  req_ready_w;
  wire  [1:0]  rsp_valid_w;
  wire  [1:0]  rsp_err_w;
  wire  [31:0] rsp_rdata_w [2];
  wire         mem_read, mem_write;
  wire  [8:0]  mem_a;
  wire  [31:0] mem_wd;
  wire  [2:0]  mem_funct3;
  wire  [31:0] mem_rd;

  logic [31:0] env_mem [128];
  logic [31:0] ref_mem [128];
  int          last_w;
  int          n_compared;
  int          n_mismatched;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(req_ready_w[0]), .req0_write(req_write[0]),
    .req0_addr(req_addr[0]), .req0_wdata(req_wdata[0]), .req0_funct3(req_funct3[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready_w[1]), .req1_write(req_write[1]),
    .req1_addr(req_addr[1]), .req1_wdata(req_wdata[1]), .req1_funct3(req_funct3[1]),
    .rsp0_valid(rsp_valid_w[0]), .rsp0_ready(rsp_rdy[0]), .rsp0_rdata(rsp_rdata_w[0]), .rsp0_err(rsp_err_w[0]),
    .rsp1_valid(rsp_valid_w[1]), .rsp1_ready(rsp_rdy[1]), .rsp1_rdata(rsp_rdata_w[1]), .rsp1_err(rsp_err_w[1]),
    .MemRead(mem_read), .MemWrite(mem_write), .a(mem_a), .wd(mem_wd), .Funct3(mem_funct3), .rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-organised data memory seen by the DUT; size codes are ignored.
  assign mem_rd = env_mem[mem_a[8:2]];
  always @(posedge clk) begin
    if (mem_write) env_mem[mem_a[8:2]] <= mem_wd;
  end

  typedef struct {
    int          port;
    logic        write;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  function automatic int pick(input logic v0, input logic v1, input int last);
    if (v0 && v1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  // An access is misaligned when the address is not a multiple of its size in bytes.
  function automatic logic model_err(input logic [2:0] f3, input logic [8:0] addr);
    int size;
    if (f3 == 3'b000 || f3 == 3'b100) size = 1;
    else if (f3 == 3'b001) size = 2;
    else size = 4;
    return (int'(addr) % size) != 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int p, input logic w, input logic [8:0] ad,
                               input logic [31:0] wdv, input logic [2:0] f);
    req_valid[p]  = 1'b1;
    req_write[p]  = w;
    req_addr[p]   = ad;
    req_wdata[p]  = wdv;
    req_funct3[p] = f;
  endtask

  // Called at a falling edge in an IDLE cycle with requests already driven.
  task automatic run_txn(input int p, input logic exp_err, input logic [31:0] exp_rdata,
                         input int hold, input string tag);
    logic        w;
    logic [8:0]  ad;
    logic [31:0] wdv;
    logic [2:0]  f;
    w   = req_write[p];
    ad  = req_addr[p];
    wdv = req_wdata[p];
    f   = req_funct3[p];
    #1;
    checkOutput($sformatf("%s.accept_ready", tag), 32'(req_ready_w), (p == 0) ? 32'd1 : 32'd2);
    checkOutput($sformatf("%s.idle_rsp_valid", tag), 32'(rsp_valid_w), 32'd0);
    checkOutput($sformatf("%s.idle_strobes", tag), 32'({mem_read, mem_write}), 32'd0);
    @(negedge clk);
    req_valid[p] = 1'b0;
    if (hold > 0) rsp_rdy[p] = 1'b0;
    if (!exp_err) begin
      #1;
      checkOutput($sformatf("%s.issue_ready", tag), 32'(req_ready_w), 32'd0);
      checkOutput($sformatf("%s.issue_strobes", tag), 32'({mem_read, mem_write}), 32'({~w, w}));
      checkOutput($sformatf("%s.issue_addr", tag), 32'(mem_a), 32'(ad));
      checkOutput($sformatf("%s.issue_funct3", tag), 32'(mem_funct3), 32'(f));
      if (w) checkOutput($sformatf("%s.issue_wd", tag), mem_wd, wdv);
      @(negedge clk);
    end
    for (int k = 0; k <= hold; k++) begin
      if (k == hold) rsp_rdy[p] = 1'b1;
      #1;
      checkOutput($sformatf("%s.rsp_valid", tag), 32'(rsp_valid_w[p]), 32'd1);
      checkOutput($sformatf("%s.rsp_other_valid", tag), 32'(rsp_valid_w[1-p]), 32'd0);
      checkOutput($sformatf("%s.rsp_rdata", tag), rsp_rdata_w[p], exp_rdata);
      checkOutput($sformatf("%s.rsp_err", tag), 32'(rsp_err_w[p]), 32'(exp_err));
      checkOutput($sformatf("%s.rsp_req_ready", tag), 32'(req_ready_w), 32'd0);
      checkOutput($sformatf("%s.rsp_strobes", tag), 32'({mem_read, mem_write}), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    int          w;
    logic        pend [2];
    logic        e;
    logic [31:0] r;
    n_compared   = 0;
    n_mismatched = 0;
    last_w       = 1;
    for (int i = 0; i < 128; i++) begin
      env_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0; req_write[p] = 1'b0; req_addr[p] = 9'h0;
      req_wdata[p] = 32'h0; req_funct3[p] = 3'b0; rsp_rdy[p] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset.req_ready", 32'(req_ready_w), 32'd0);
    checkOutput("reset.rsp_valid", 32'(rsp_valid_w), 32'd0);
    checkOutput("reset.rsp_err", 32'(rsp_err_w), 32'd0);
    checkOutput("reset.rsp0_rdata", rsp_rdata_w[0], 32'd0);
    checkOutput("reset.rsp1_rdata", rsp_rdata_w[1], 32'd0);
    checkOutput("reset.strobes", 32'({mem_read, mem_write}), 32'd0);
    checkOutput("reset.a", 32'(mem_a), 32'd0);
    checkOutput("reset.wd", mem_wd, 32'd0);
    checkOutput("reset.funct3", 32'(mem_funct3), 32'd0);
    @(negedge clk);

    // Directed single-port vectors.
    vecs[0]  = '{0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 9'h010, 32'h0,        3'b010, 0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1, 1'b0, 9'h003, 32'h0,        3'b001, 0, 1'b1, 32'h0};
    vecs[3]  = '{1, 1'b1, 9'h020, 32'h12345678, 3'b010, 2, 1'b0, 32'h0};
    vecs[4]  = '{0, 1'b0, 9'h020, 32'h0,        3'b001, 0, 1'b0, 32'h12345678};
    vecs[5]  = '{0, 1'b0, 9'h023, 32'h0,        3'b100, 0, 1'b0, 32'h12345678};
    vecs[6]  = '{1, 1'b0, 9'h022, 32'h0,        3'b010, 0, 1'b1, 32'h0};
    vecs[7]  = '{0, 1'b0, 9'h004, 32'h0,        3'b011, 0, 1'b0, 32'h0};
    vecs[8]  = '{1, 1'b0, 9'h006, 32'h0,        3'b111, 0, 1'b1, 32'h0};
    vecs[9]  = '{0, 1'b1, 9'h011, 32'h55555555, 3'b010, 0, 1'b1, 32'h0};
    vecs[10] = '{1, 1'b0, 9'h010, 32'h0,        3'b010, 1, 1'b0, 32'hDEADBEEF};
    vecs[11] = '{1, 1'b1, 9'h031, 32'h000000A5, 3'b000, 0, 1'b0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].port, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].f3);
      run_txn(vecs[i].port, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].hold, $sformatf("vec%0d", i));
      if (vecs[i].write && !vecs[i].exp_err) ref_mem[vecs[i].addr[8:2]] = vecs[i].wdata;
      last_w = vecs[i].port;
    end

    // Port 0 response stalled for 5 cycles while port 1 waits with a stable request.
    applyStimulus(0, 1'b0, 9'h010, 32'h0, 3'b010);
    applyStimulus(1, 1'b0, 9'h024, 32'h0, 3'b010);
    w = pick(1'b1, 1'b1, last_w);
    run_txn(w, 1'b0, ref_mem[req_addr[w][8:2]], 5, "hold_first");
    last_w = w;
    w = pick(req_valid[0], req_valid[1], last_w);
    run_txn(w, 1'b0, ref_mem[req_addr[w][8:2]], 0, "hold_second");
    last_w = w;

    // Both ports continuously requesting.
    applyStimulus(0, 1'b0, 9'h010, 32'h0, 3'b010);
    applyStimulus(1, 1'b0, 9'h020, 32'h0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      w = pick(1'b1, 1'b1, last_w);
      run_txn(w, 1'b0, ref_mem[req_addr[w][8:2]], 0, $sformatf("tie%0d", i));
      last_w = w;
      req_valid[w] = 1'b1;
    end
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;

    // Randomized traffic; a losing request stays pending with its payload untouched.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          applyStimulus(p, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 255)), $urandom, 3'($urandom_range(0, 7)));
          pend[p] = 1'b1;
        end
      end
      if (!pend[0] && !pend[1]) begin
        w = int'($urandom_range(0, 1));
        applyStimulus(w, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 255)), $urandom, 3'($urandom_range(0, 7)));
        pend[w] = 1'b1;
      end
      w = pick(pend[0], pend[1], last_w);
      e = model_err(req_funct3[w], req_addr[w]);
      r = (req_write[w] || e) ? 32'h0 : ref_mem[req_addr[w][8:2]];
      if (req_write[w] && !e) ref_mem[req_addr[w][8:2]] = req_wdata[w];
      run_txn(w, e, r, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
      last_w  = w;
      pend[w] = 1'b0;
    end
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);

    // Reset during the ISSUE cycle of a port 0 store.
    applyStimulus(0, 1'b1, 9'h1F0, 32'hCAFEF00D, 3'b010);
    #1;
    checkOutput("rst.accept_ready", 32'(req_ready_w), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst.issue_strobes", 32'({mem_read, mem_write}), 32'b01);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst.after_strobes", 32'({mem_read, mem_write}), 32'd0);
    checkOutput("rst.after_rsp_valid", 32'(rsp_valid_w), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rst.later_rsp_valid", 32'(rsp_valid_w), 32'd0);
    checkOutput("rst.later_strobes", 32'({mem_read, mem_write}), 32'd0);
    @(negedge clk);
    last_w = 1;
    applyStimulus(0, 1'b0, 9'h010, 32'h0, 3'b010);
    applyStimulus(1, 1'b0, 9'h020, 32'h0, 3'b010);
    w = pick(1'b1, 1'b1, last_w);
    run_txn(w, 1'b0, ref_mem[req_addr[w][8:2]], 0, "rst_tie");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the data memory (9-bit byte address, 32-bit data, RISC-V Funct3 size encoding).
- Port 0 is the pipeline load/store path; port 1 is a DMA/debug master.
- Accepts one request per transaction, drives MemRead/MemWrite/a/wd/Funct3 for exactly one cycle, captures read data and returns a tagged response.
- Rejects misaligned accesses with an error response and no memory cycle.

Parameters:
- DM_ADDRESS, 9, byte-address width into data memory.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request valid, N=0,1.
- reqN_ready  out  1  request accepted this cycle, N=0,1.
- reqN_write  in  1  1=store, 0=load.
- reqN_addr  in  DM_ADDRESS  byte address.
- reqN_wdata  in  DATA_W  store data.
- reqN_funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU.
- rspN_valid  out  1  response valid, held until rspN_ready.
- rspN_ready  in  1  response consumed.
- rspN_rdata  out  DATA_W  load data; 0 for stores and errors.
- rspN_err  out  1  misaligned-access error flag.
- MemRead  out  1  to data memory.
- MemWrite  out  1  to data memory.
- a  out  DM_ADDRESS  memory address.
- wd  out  DATA_W  memory write data.
- Funct3  out  3  memory size code.
- rd  in  DATA_W  memory read data, combinational from a/Funct3.

Behaviour:
- Reset values: FSM = IDLE; every reqN_ready, rspN_valid, rspN_err = 0; every rspN_rdata = 0; MemRead = MemWrite = 0; a, wd, Funct3 = 0; last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any reqN_valid, pick a winner: if only one port is valid, that port wins; if both are valid, the port != last_grant wins (round-robin).
  - reqN_ready = 1 for the winner only, combinationally, in the same cycle. The request is accepted on that edge.
  - Latch write, addr, wdata, funct3 and id into command registers; update last_grant.
  - Alignment check on the latched command: a word with addr[1:0] != 0 is misaligned; a half with addr[0] != 0 is misaligned.
  - Misaligned: go to RESP with err = 1, rdata = 0. Aligned: go to ISSUE.
- ISSUE (exactly 1 cycle):
  - MemRead = ~cmd_write; MemWrite = cmd_write; a/wd/Funct3 driven from command registers.
  - Loads: rd is captured into the response data register at the closing edge.
  - Stores: response data = 0.
  - Next state RESP.
- RESP:
  - rsp[cmd_id]_valid = 1 with rdata/err stable; the other port's rsp_valid stays 0.
  - Hold until rsp[cmd_id]_ready = 1, then IDLE.
  - No new request is accepted while in ISSUE or RESP: both reqN_ready = 0.
- Timing:
  - Aligned access: accept edge → ISSUE (1 cycle) → RESP visible 2 cycles after acceptance.
  - Minimum 3 cycles per transaction with rsp_ready tied high.
- Memory strobes are 0 in every state except ISSUE. MemRead and MemWrite are never both 1.
- A request held valid while the other port is served must not be dropped; its payload must stay stable until ready.
- Reset asserted in any state: next state IDLE, in-flight command discarded, no response issued, strobes 0 from the cycle after the reset edge.
- Funct3 codes outside {000, 001, 010, 100}: treated as word for the alignment check and passed through unchanged.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins when both ports are valid, and last_grant is unused.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then req0 store word addr 0x010 wdata 0xDEADBEEF → req0_ready pulse; next cycle MemWrite = 1, a = 0x010, Funct3 = 010; rsp0_valid 2 cycles after accept, rdata = 0, err = 0.
- req0 load word addr 0x010 (memory model returns 0xDEADBEEF) → MemRead = 1 for 1 cycle; rsp0_rdata = 0xDEADBEEF; rsp1_valid stays 0.
- Both ports valid continuously, rsp_ready high → grants alternate 0, 1, 0, 1, one accept every 3 cycles. With DMEM_ARB_FIXED_PRIO_EN defined, port 1 is never granted.
- req1 load half addr 0x003 → no MemRead/MemWrite pulse; rsp1_valid with err = 1, rdata = 0, one cycle after accept.
- rsp0_ready held low for 5 cycles → rsp0_valid and rsp0_rdata stable for all 5 cycles; req1_ready stays 0 meanwhile; req1 accepted in the first IDLE cycle after release.
- reset asserted during ISSUE of a store → MemWrite low the next cycle, no rspN_valid, FSM in IDLE, port 0 wins the next tie.
